yarvi_commit_trace: RTL and testbench

//   Parametrised commit/writeback trace stage for the YARVI pipeline. Captures every

---
 rtl/yarvi_commit_trace.sv | 168 ++++++++++++++++
 tb/tb_yarvi_commit_trace.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_commit_trace.sv
// yarvi_commit_trace: retirement trace FIFO between ME and a trace sink.
// Every ME retirement is queued (priv, pc, insn, rd, value) and drained over a
// valid/ready port. Lossless builds raise freeze with hysteresis so that the
// retirements still in flight always find room. Lossy builds never stall and
// count the entries they drop instead.
module yarvi_commit_trace #(
  parameter int XLEN  = 32,
  parameter int VLEN  = 32,
  parameter int DEPTH = 16,
  parameter int SKID  = 3,
  parameter int LOSSY = 0,
  parameter int CNT_W = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   me_valid,
  input  logic [1:0]             me_priv,
  input  logic [VLEN-1:0]        me_pc,
  input  logic [31:0]            me_insn,
  input  logic [4:0]             me_wb_rd,
  input  logic [XLEN-1:0]        me_wb_val,
  input  logic                   flush,
  output logic                   freeze,
  output logic                   tr_valid,
  input  logic                   tr_ready,
  output logic [1:0]             tr_priv,
  output logic [VLEN-1:0]        tr_pc,
  output logic [31:0]            tr_insn,
  output logic [4:0]             tr_rd,
  output logic [XLEN-1:0]        tr_val,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       retired,
  output logic [CNT_W-1:0]       dropped,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_HI   = (AW+1)'(DEPTH - SKID);
  localparam logic [AW:0] LVL_LO   = (AW+1)'(DEPTH / 2);

  typedef struct packed {
    logic [1:0]      priv;
    logic [VLEN-1:0] pc;
    logic [31:0]     insn;
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
  } entry_t;

  typedef enum logic {RUN, HOLD} state_t;

  entry_t           mem_q [DEPTH];
  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [AW:0]      head_q, head_d;
  logic [AW:0]      tail_q, tail_d;
  logic [AW:0]      level_d;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] dropped_q;
  logic             overflow_q;
  state_t           state_q;
  logic             freeze_q;

  logic   push;
  logic   pop;
  logic   drop;
  entry_t head_ent;

  assign level    = tail_q - head_q;
  assign tr_valid = (level != '0);
  assign pop      = tr_valid && tr_ready;
  // A full FIFO still accepts a retirement when the sink frees a slot this cycle.
  assign push     = me_valid && !flush && ((level != LVL_FULL) || pop);
  assign drop     = me_valid && !flush && (level == LVL_FULL) && !pop;

  // Head fields are masked while empty so stale storage never leaks out,
  // including immediately after an asynchronous reset.
  assign head_ent = mem_q[head_q[AW-1:0]];
  assign tr_priv  = tr_valid ? head_ent.priv : '0;
  assign tr_pc    = tr_valid ? head_ent.pc   : '0;
  assign tr_insn  = tr_valid ? head_ent.insn : '0;
  assign tr_rd    = tr_valid ? head_ent.rd   : '0;
  assign tr_val   = tr_valid ? head_ent.val  : '0;

  assign retired  = retired_q;
  assign dropped  = dropped_q;
  assign overflow = overflow_q;
  assign freeze   = freeze_q;

  // Next pointers and next occupancy; flush empties the queue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push && !pop)      level_d = level + 1'b1;
      else if (pop && !push) level_d = level - 1'b1;
    end
  end

  // Entry storage: data only, never reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[tail_q[AW-1:0]] <= '{priv: me_priv, pc: me_pc, insn: me_insn,
                                         rd: me_wb_rd, val: me_wb_val};
  end

  // Head and tail pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Retired (wrapping) and dropped (saturating) counters plus sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q  <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (me_valid) retired_q <= retired_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != {CNT_W{1'b1}}) dropped_q <= dropped_q + 1'b1;
      end
    end
  end

  // Freeze hysteresis: enter HOLD early enough that SKID in-flight
  // retirements still fit, release once the queue is half drained.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      freeze_q <= 1'b0;
    end else if ((LOSSY != 0) || flush) begin
      state_q  <= RUN;
      freeze_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (level_d >= LVL_HI) begin
            state_q  <= HOLD;
            freeze_q <= 1'b1;
          end
        end
        HOLD: begin
          if (level_d <= LVL_LO) begin
            state_q  <= RUN;
            freeze_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          freeze_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yarvi_commit_trace.sv
// tb_yarvi_commit_trace: drives a lossless and a lossy instance side by side
// and compares both against a queue-based reference model.
module tb_yarvi_commit_trace;
  localparam int DEPTH = 16;
  localparam int SKID  = 3;

  typedef struct packed {
    logic [1:0]  priv;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        v0 = 1'b0, r0 = 1'b0, v1 = 1'b0, r1 = 1'b0;
  logic [1:0]  me_priv = '0;
  logic [31:0] me_pc = '0, me_insn = '0, me_wb_val = '0;
  logic [4:0]  me_wb_rd = '0;

  logic        fz0, tv0, ovf0, fz1, tv1, ovf1;
  logic [1:0]  tp0, tp1;
  logic [31:0] tpc0, ti0, tval0, tpc1, ti1, tval1;
  logic [4:0]  trd0, trd1, lvl0, lvl1;
  logic [63:0] ret0, drp0;
  logic [3:0]  ret1, drp1;
  ent_t        g0, g1;

  assign g0 = {tp0, tpc0, ti0, trd0, tval0};
  assign g1 = {tp1, tpc1, ti1, trd1, tval1};

  yarvi_commit_trace #(.XLEN(32), .VLEN(32), .DEPTH(DEPTH), .SKID(SKID), .LOSSY(0), .CNT_W(64)) u_lossless (
    .clock(clock), .reset(reset), .me_valid(v0), .me_priv(me_priv), .me_pc(me_pc),
    .me_insn(me_insn), .me_wb_rd(me_wb_rd), .me_wb_val(me_wb_val), .flush(flush),
    .freeze(fz0), .tr_valid(tv0), .tr_ready(r0), .tr_priv(tp0), .tr_pc(tpc0),
    .tr_insn(ti0), .tr_rd(trd0), .tr_val(tval0), .level(lvl0), .retired(ret0),
    .dropped(drp0), .overflow(ovf0));

  yarvi_commit_trace #(.XLEN(32), .VLEN(32), .DEPTH(DEPTH), .SKID(SKID), .LOSSY(1), .CNT_W(4)) u_lossy (
    .clock(clock), .reset(reset), .me_valid(v1), .me_priv(me_priv), .me_pc(me_pc),
    .me_insn(me_insn), .me_wb_rd(me_wb_rd), .me_wb_val(me_wb_val), .flush(flush),
    .freeze(fz1), .tr_valid(tv1), .tr_ready(r1), .tr_priv(tp1), .tr_pc(tpc1),
    .tr_insn(ti1), .tr_rd(trd1), .tr_val(tval1), .level(lvl1), .retired(ret1),
    .dropped(drp1), .overflow(ovf1));

  always #5 clock = ~clock;

  // Reference model state
  ent_t        q0[$];
  ent_t        q1[$];
  logic [63:0] m_ret0, m_drp0;
  logic [3:0]  m_ret1, m_drp1;
  logic        m_ovf0, m_ovf1, m_hold0;
  int          errors = 0;
  int          checks = 0;

  function automatic ent_t rnd();
    ent_t e;
    e.priv = 2'($urandom);
    e.pc   = $urandom;
    e.insn = $urandom;
    e.rd   = 5'($urandom);
    e.val  = $urandom;
    return e;
  endfunction

  function automatic void model_clear();
    q0.delete();
    q1.delete();
    m_ret0 = '0; m_drp0 = '0; m_ret1 = '0; m_drp1 = '0;
    m_ovf0 = 1'b0; m_ovf1 = 1'b0; m_hold0 = 1'b0;
  endfunction

  function automatic void upd0(input logic v, input logic r, input logic fl, input ent_t e);
    if (v) m_ret0 = m_ret0 + 1;
    if (fl) begin
      q0.delete();
      m_hold0 = 1'b0;
      return;
    end
    if (r && q0.size() != 0) void'(q0.pop_front());
    if (v) begin
      if (q0.size() < DEPTH) q0.push_back(e);
      else begin
        m_ovf0 = 1'b1;
        if (m_drp0 != 64'hFFFF_FFFF_FFFF_FFFF) m_drp0 = m_drp0 + 1;
      end
    end
    if (q0.size() >= DEPTH - SKID) m_hold0 = 1'b1;
    else if (q0.size() <= DEPTH / 2) m_hold0 = 1'b0;
  endfunction

  function automatic void upd1(input logic v, input logic r, input logic fl, input ent_t e);
    if (v) m_ret1 = m_ret1 + 1;
    if (fl) begin
      q1.delete();
      return;
    end
    if (r && q1.size() != 0) void'(q1.pop_front());
    if (v) begin
      if (q1.size() < DEPTH) q1.push_back(e);
      else begin
        m_ovf1 = 1'b1;
        if (m_drp1 != 4'hF) m_drp1 = m_drp1 + 1;
      end
    end
  endfunction

  // One clock: drive on the falling edge, update model at the rising edge,
  // return 1 time unit later with outputs settled.
  task automatic step(input logic a_v0, input logic a_r0, input logic a_v1,
                      input logic a_r1, input logic a_fl, input ent_t e);
    @(negedge clock);
    v0 = a_v0; r0 = a_r0; v1 = a_v1; r1 = a_r1; flush = a_fl;
    {me_priv, me_pc, me_insn, me_wb_rd, me_wb_val} = e;
    @(posedge clock);
    upd0(a_v0, a_r0, a_fl, e);
    upd1(a_v1, a_r1, a_fl, e);
    #1;
  endtask

  task automatic test_reset();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({fz0, tv0, ovf0, lvl0, g0, ret0, drp0} !== '0) begin
      errors++;
      $display("FAIL reset_lossless got fz=%b tv=%b ovf=%b lvl=%0d ret=%0d drp=%0d tr=%h required all zero",
               fz0, tv0, ovf0, lvl0, ret0, drp0, g0);
    end
    checks++;
    if ({fz1, tv1, ovf1, lvl1, g1, ret1, drp1} !== '0) begin
      errors++;
      $display("FAIL reset_lossy got fz=%b tv=%b ovf=%b lvl=%0d ret=%0d drp=%0d tr=%h required all zero",
               fz1, tv1, ovf1, lvl1, ret1, drp1, g1);
    end
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 0, 0, 0, rnd());
    checks++;
    if ({tv0, lvl0, tv1, lvl1} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got tv0=%b lvl0=%0d tv1=%b lvl1=%0d required 0", tv0, lvl0, tv1, lvl1);
    end
  endtask

  task automatic test_first_push();
    ent_t e;
    e.priv = 2'd3; e.pc = 32'h100; e.insn = 32'h0050_0093; e.rd = 5'd1; e.val = 32'd5;
    step(1, 0, 1, 0, 0, e);
    checks++;
    if ({tv0, tpc0, tval0, ti0, trd0} !== {1'b1, 32'h100, 32'd5, 32'h0050_0093, 5'd1}) begin
      errors++;
      $display("FAIL first_push_lossless got tv=%b pc=%h val=%0d insn=%h rd=%0d required tv=1 pc=100 val=5 insn=00500093 rd=1",
               tv0, tpc0, tval0, ti0, trd0);
    end
    checks++;
    if (ret0 !== 64'd1 || ret1 !== 4'd1) begin
      errors++;
      $display("FAIL first_push_retired got %0d/%0d required 1/1", ret0, ret1);
    end
    checks++;
    if ({tv1, tpc1, tval1, tp1} !== {1'b1, 32'h100, 32'd5, 2'd3}) begin
      errors++;
      $display("FAIL first_push_lossy got tv=%b pc=%h val=%0d priv=%0d required tv=1 pc=100 val=5 priv=3",
               tv1, tpc1, tval1, tp1);
    end
    step(0, 1, 0, 1, 0, rnd());
    checks++;
    if ({tv0, lvl0, tv1, lvl1} !== '0) begin
      errors++;
      $display("FAIL first_pop got tv0=%b lvl0=%0d tv1=%b lvl1=%0d required empty", tv0, lvl0, tv1, lvl1);
    end
  endtask

  task automatic test_fill_freeze();
    for (int i = 1; i <= 13; i++) begin
      step(1, 0, 0, 0, 0, rnd());
      checks++;
      if (fz0 !== (i >= 13)) begin
        errors++;
        $display("FAIL freeze_rise push=%0d got %b required %b", i, fz0, (i >= 13));
      end
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, rnd());
    checks++;
    if ({lvl0, drp0, ovf0, fz0} !== {5'd16, 64'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fill_full got lvl=%0d drp=%0d ovf=%b fz=%b required lvl=16 drp=0 ovf=0 fz=1",
               lvl0, drp0, ovf0, fz0);
    end
    checks++;
    if (g0 !== q0[0]) begin
      errors++;
      $display("FAIL fill_head got %h required %h", g0, q0[0]);
    end
  endtask

  task automatic test_full_push_pop();
    ent_t nxt;
    nxt = q0[1];
    step(1, 1, 0, 0, 0, rnd());
    checks++;
    if ({lvl0, drp0, ovf0} !== {5'd16, 64'd0, 1'b0}) begin
      errors++;
      $display("FAIL full_push_pop got lvl=%0d drp=%0d ovf=%b required lvl=16 drp=0 ovf=0", lvl0, drp0, ovf0);
    end
    checks++;
    if (g0 !== nxt) begin
      errors++;
      $display("FAIL full_push_pop_head got %h required %h", g0, nxt);
    end
  endtask

  task automatic test_drain_unfreeze();
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 0, 0, 0, rnd());
      checks++;
      if (lvl0 !== 5'(16 - k) || fz0 !== ((16 - k) > DEPTH / 2)) begin
        errors++;
        $display("FAIL drain pop=%0d got lvl=%0d fz=%b required lvl=%0d fz=%b",
                 k, lvl0, fz0, 16 - k, ((16 - k) > DEPTH / 2));
      end
      if (q0.size() != 0) begin
        checks++;
        if (g0 !== q0[0]) begin
          errors++;
          $display("FAIL drain_head pop=%0d got %h required %h", k, g0, q0[0]);
        end
      end
    end
  endtask

  task automatic test_lossy();
    ent_t e;
    logic [31:0] first_pc;
    for (int i = 0; i < 20; i++) begin
      e = rnd();
      if (i == 0) first_pc = e.pc;
      step(0, 0, 1, 0, 0, e);
      checks++;
      if (fz1 !== 1'b0) begin
        errors++;
        $display("FAIL lossy_freeze push=%0d got %b required 0", i, fz1);
      end
    end
    checks++;
    if ({lvl1, drp1, ovf1, tpc1} !== {5'd16, 4'd4, 1'b1, first_pc}) begin
      errors++;
      $display("FAIL lossy_full got lvl=%0d drp=%0d ovf=%b pc=%h required lvl=16 drp=4 ovf=1 pc=%h",
               lvl1, drp1, ovf1, tpc1, first_pc);
    end
    step(0, 0, 1, 1, 0, rnd());
    checks++;
    if ({lvl1, drp1} !== {5'd16, 4'd4} || g1 !== q1[0]) begin
      errors++;
      $display("FAIL lossy_push_pop got lvl=%0d drp=%0d head=%h required lvl=16 drp=4 head=%h",
               lvl1, drp1, g1, q1[0]);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, rnd());
    checks++;
    if (drp1 !== 4'hF || ret1 !== m_ret1) begin
      errors++;
      $display("FAIL lossy_saturate got drp=%0d ret=%0d required drp=15 ret=%0d", drp1, ret1, m_ret1);
    end
    step(0, 0, 0, 0, 1, rnd());
    checks++;
    if ({lvl1, tv1, ovf1, drp1} !== {5'd0, 1'b0, 1'b1, 4'hF}) begin
      errors++;
      $display("FAIL lossy_flush got lvl=%0d tv=%b ovf=%b drp=%0d required lvl=0 tv=0 ovf=1 drp=15",
               lvl1, tv1, ovf1, drp1);
    end
  endtask

  task automatic test_flush();
    logic [63:0] exp_ret;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, rnd());
    checks++;
    if (lvl0 !== 5'd5) begin
      errors++;
      $display("FAIL flush_prefill got lvl=%0d required 5", lvl0);
    end
    exp_ret = m_ret0 + 1;
    step(1, 0, 0, 0, 1, rnd());
    checks++;
    if ({lvl0, tv0, fz0} !== {5'd0, 1'b0, 1'b0} || ret0 !== exp_ret) begin
      errors++;
      $display("FAIL flush got lvl=%0d tv=%b fz=%b ret=%0d required lvl=0 tv=0 fz=0 ret=%0d",
               lvl0, tv0, fz0, ret0, exp_ret);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, rnd());
    step(0, 1, 0, 1, 0, rnd());
    step(0, 1, 0, 1, 0, rnd());
    #2;
    reset = 1'b1;
    v0 = 1'b0; r0 = 1'b0; v1 = 1'b0; r1 = 1'b0;
    #1;
    checks++;
    if ({fz0, tv0, ovf0, lvl0, g0, ret0, drp0} !== '0) begin
      errors++;
      $display("FAIL reset_mid_drain_lossless got tv=%b lvl=%0d ret=%0d tr=%h required all zero", tv0, lvl0, ret0, g0);
    end
    checks++;
    if ({fz1, tv1, ovf1, lvl1, g1, ret1, drp1} !== '0) begin
      errors++;
      $display("FAIL reset_mid_drain_lossy got tv=%b lvl=%0d ret=%0d ovf=%b tr=%h required all zero",
               tv1, lvl1, ret1, ovf1, g1);
    end
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int   sk = 0;
    int   rp;
    logic a_v0, a_r0, a_v1, a_r1, a_fl;
    for (int c = 0; c < 3000; c++) begin
      rp   = ((c / 256) % 2 == 0) ? 25 : 75;
      a_r0 = ($urandom_range(0, 99) < rp);
      a_r1 = ($urandom_range(0, 99) < rp);
      a_v1 = ($urandom_range(0, 99) < 65);
      a_fl = ($urandom_range(0, 63) == 0);
      // Core behaviour: at most SKID retirements once freeze is seen.
      if (!fz0) sk = 0;
      a_v0 = ($urandom_range(0, 99) < 70);
      if (fz0 && sk >= SKID) a_v0 = 1'b0;
      if (fz0 && a_v0) sk++;
      step(a_v0, a_r0, a_v1, a_r1, a_fl, rnd());
      checks++;
      if ({tv0, fz0, ovf0, lvl0} !== {q0.size() != 0, m_hold0, m_ovf0, 5'(q0.size())}) begin
        errors++;
        $display("FAIL rand_state0 cyc=%0d got tv=%b fz=%b ovf=%b lvl=%0d required tv=%b fz=%b ovf=%b lvl=%0d",
                 c, tv0, fz0, ovf0, lvl0, q0.size() != 0, m_hold0, m_ovf0, q0.size());
      end
      checks++;
      if (ret0 !== m_ret0 || drp0 !== 64'd0) begin
        errors++;
        $display("FAIL rand_cnt0 cyc=%0d got ret=%0d drp=%0d required ret=%0d drp=0", c, ret0, drp0, m_ret0);
      end
      checks++;
      if ({tv1, fz1, ovf1, lvl1, ret1, drp1} !==
          {q1.size() != 0, 1'b0, m_ovf1, 5'(q1.size()), m_ret1, m_drp1}) begin
        errors++;
        $display("FAIL rand_state1 cyc=%0d got tv=%b fz=%b ovf=%b lvl=%0d ret=%0d drp=%0d required tv=%b fz=0 ovf=%b lvl=%0d ret=%0d drp=%0d",
                 c, tv1, fz1, ovf1, lvl1, ret1, drp1, q1.size() != 0, m_ovf1, q1.size(), m_ret1, m_drp1);
      end
      if (q0.size() != 0) begin
        checks++;
        if (g0 !== q0[0]) begin
          errors++;
          $display("FAIL rand_head0 cyc=%0d got %h required %h", c, g0, q0[0]);
        end
      end
      if (q1.size() != 0) begin
        checks++;
        if (g1 !== q1[0]) begin
          errors++;
          $display("FAIL rand_head1 cyc=%0d got %h required %h", c, g1, q1[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill_freeze();
    test_full_push_pop();
    test_drain_unfreeze();
    test_lossy();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
